// File: rtl/pr_rank_sorter_if.sv
// Valid/ready bundle for the rank sorter: the upstream entry stream and the downstream sorted stream.
// The sorter connects through the slave modport; the producer/consumer side uses master.
interface pr_rank_sorter_if #(
    parameter int SCORE_W = 4,
    parameter int ID_W    = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [SCORE_W-1:0] in_score;
    logic [ID_W-1:0]    in_id;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [SCORE_W-1:0] out_score;
    logic [ID_W-1:0]    out_id;
    logic               out_last;

    modport master (
        output in_valid, in_score, in_id, in_last, out_ready,
        input  in_ready, out_valid, out_score, out_id, out_last
    );

    modport slave (
        input  in_valid, in_score, in_id, in_last, out_ready,
        output in_ready, out_valid, out_score, out_id, out_last
    );
endinterface

// File: rtl/pr_rank_sorter.sv
// Insertion sorter: loads a batch of (score, id) entries, then drains them highest score first.
// Optional macro RANK_IDX_EN adds out_rank, the 0-based position of the current output in its batch.
module pr_rank_sorter #(
    parameter int SCORE_W = 4,
    parameter int ID_W    = 4,
    parameter int DEPTH   = 8,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int RANK_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    pr_rank_sorter_if.slave    bus,
`ifdef RANK_IDX_EN
    output logic [RANK_W-1:0]  out_rank,
`endif
    output logic               busy
);
    typedef enum logic {LOAD, DRAIN} state_t;

    state_t             r_state, w_next_state;
    logic [SCORE_W-1:0] r_score [DEPTH];
    logic [ID_W-1:0]    r_id    [DEPTH];
    logic [CNT_W-1:0]   r_count;

    logic               w_accept;
    logic               w_pop;
    logic [DEPTH-1:0]   w_ge;
    logic [SCORE_W-1:0] w_ins_score [DEPTH];
    logic [ID_W-1:0]    w_ins_id    [DEPTH];
    logic [SCORE_W-1:0] w_pop_score [DEPTH];
    logic [ID_W-1:0]    w_pop_id    [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= LOAD;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_pop         = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (r_state)
            LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    if (bus.in_last || (r_count == CNT_W'(DEPTH - 1)))
                        w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_pop = 1'b1;
                    if (r_count == CNT_W'(1))
                        w_next_state = LOAD;
                end
            end
            default: w_next_state = LOAD;
        endcase
    end

    // Occupied slots holding a score >= the incoming one form a prefix, so each slot
    // decides keep / take-new / take-from-above from its own and its neighbour's compare.
    always_comb begin
        w_ge = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            w_ge[i] = (CNT_W'(i) < r_count) && (r_score[i] >= bus.in_score);

        w_ins_score[0] = w_ge[0] ? r_score[0] : bus.in_score;
        w_ins_id[0]    = w_ge[0] ? r_id[0]    : bus.in_id;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (w_ge[i]) begin
                w_ins_score[i] = r_score[i];
                w_ins_id[i]    = r_id[i];
            end else if (w_ge[i-1]) begin
                w_ins_score[i] = bus.in_score;
                w_ins_id[i]    = bus.in_id;
            end else begin
                w_ins_score[i] = r_score[i-1];
                w_ins_id[i]    = r_id[i-1];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            w_pop_score[i] = r_score[i+1];
            w_pop_id[i]    = r_id[i+1];
        end
        w_pop_score[DEPTH-1] = '0;
        w_pop_id[DEPTH-1]    = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_score[i] <= '0;
                r_id[i]    <= '0;
            end
            r_count <= '0;
        end else if (w_accept) begin
            r_score <= w_ins_score;
            r_id    <= w_ins_id;
            r_count <= r_count + CNT_W'(1);
        end else if (w_pop) begin
            r_score <= w_pop_score;
            r_id    <= w_pop_id;
            r_count <= r_count - CNT_W'(1);
        end
    end

`ifdef RANK_IDX_EN
    logic [RANK_W-1:0] r_rank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rank <= '0;
        end else if (w_pop) begin
            if (r_count == CNT_W'(1)) r_rank <= '0;
            else                      r_rank <= r_rank + RANK_W'(1);
        end
    end

    assign out_rank = r_rank;
`endif

    assign bus.out_score = r_score[0];
    assign bus.out_id    = r_id[0];
    assign bus.out_last  = (r_state == DRAIN) && (r_count == CNT_W'(1));
    assign busy          = (r_state == DRAIN) || (r_count != '0);
endmodule

// File: tb/tb_pr_rank_sorter.sv
// Directed bench for pr_rank_sorter: table-driven batches plus hand sequences for stalls and reset.
module tb_pr_rank_sorter;
    logic clk;
    logic rst;
    logic busy;
    int   n_checks;
    int   n_err;

    pr_rank_sorter_if #(.SCORE_W(4), .ID_W(4)) bus ();

`ifdef RANK_IDX_EN
    logic [2:0] out_rank;
    int         exp_rank;
`endif

    pr_rank_sorter #(.SCORE_W(4), .ID_W(4), .DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
`ifdef RANK_IDX_EN
        .out_rank (out_rank),
`endif
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] s;
        logic [3:0] id;
        logic       last;
        logic [3:0] es;
        logic [3:0] eid;
        logic       elast;
    } vec_t;

    vec_t t1 [4];
    vec_t t5 [4];
    vec_t t6 [3];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_hs(input logic last);
`ifdef RANK_IDX_EN
        if (last) exp_rank = 0;
        else      exp_rank++;
`endif
    endtask

    task automatic push(input logic [3:0] s, input logic [3:0] id, input logic last);
        int k;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_score = s;
        bus.in_id    = id;
        bus.in_last  = last;
        k = 0;
        while (!bus.in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL push_timeout: in_ready got 0 expected 1 (score %0d id %0d)", s, id);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic pop(input logic [3:0] es, input logic [3:0] eid, input logic elast);
        int k;
        @(negedge clk);
        k = 0;
        while (!bus.out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("out_valid", int'(bus.out_valid), 1);
        chk("out_score", int'(bus.out_score), int'(es));
        chk("out_id", int'(bus.out_id), int'(eid));
        chk("out_last", int'(bus.out_last), int'(elast));
`ifdef RANK_IDX_EN
        chk("out_rank", int'(out_rank), exp_rank);
`endif
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        model_hs(elast);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
`ifdef RANK_IDX_EN
        exp_rank = 0;
`endif
        bus.in_valid  = 1'b0;
        bus.in_score  = '0;
        bus.in_id     = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;

        //            s      id     last   es     eid    elast
        t1[0] = '{4'd3,  4'd0, 1'b0, 4'd9,  4'd1, 1'b0};
        t1[1] = '{4'd9,  4'd1, 1'b0, 4'd9,  4'd3, 1'b0};
        t1[2] = '{4'd1,  4'd2, 1'b0, 4'd3,  4'd0, 1'b0};
        t1[3] = '{4'd9,  4'd3, 1'b1, 4'd1,  4'd2, 1'b1};
        t5[0] = '{4'd8,  4'd1, 1'b0, 4'd11, 4'd3, 1'b0};
        t5[1] = '{4'd2,  4'd2, 1'b0, 4'd8,  4'd1, 1'b0};
        t5[2] = '{4'd11, 4'd3, 1'b0, 4'd5,  4'd4, 1'b0};
        t5[3] = '{4'd5,  4'd4, 1'b1, 4'd2,  4'd2, 1'b1};
        t6[0] = '{4'd4,  4'd7, 1'b0, 4'd6,  4'd8, 1'b0};
        t6[1] = '{4'd6,  4'd8, 1'b0, 4'd4,  4'd7, 1'b0};
        t6[2] = '{4'd1,  4'd9, 1'b1, 4'd1,  4'd9, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_score", int'(bus.out_score), 0);
        chk("rst_out_last", int'(bus.out_last), 0);
        rst = 1'b0;

        // Basic batch with a tie between ids 1 and 3
        for (int i = 0; i < 4; i++) push(t1[i].s, t1[i].id, t1[i].last);
        chk("t1_in_ready_drain", int'(bus.in_ready), 0);
        chk("t1_busy_drain", int'(busy), 1);
        for (int i = 0; i < 4; i++) pop(t1[i].es, t1[i].eid, t1[i].elast);
        chk("t1_in_ready_after", int'(bus.in_ready), 1);
        chk("t1_busy_after", int'(busy), 0);

        // Full batch ends without in_last; a held in_valid must wait for the drain
        for (int i = 0; i < 8; i++) push(4'(i), 4'(i), 1'b0);
        bus.in_valid = 1'b1;
        bus.in_score = 4'd15;
        bus.in_id    = 4'd9;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t2_in_ready", int'(bus.in_ready), 0);
            chk("t2_hold_score", int'(bus.out_score), 7);
            chk("t2_hold_id", int'(bus.out_id), 7);
        end
        for (int i = 7; i >= 0; i--) pop(4'(i), 4'(i), (i == 0));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        pop(4'd15, 4'd9, 1'b1);

        // Equal scores with in_last on the DEPTH-th entry: stable order, one transition
        for (int i = 0; i < 8; i++) push(4'd5, 4'(i), (i == 7));
        for (int i = 0; i < 8; i++) pop(4'd5, 4'(i), (i == 7));
        chk("t3_in_ready_after", int'(bus.in_ready), 1);
        chk("t3_out_valid_after", int'(bus.out_valid), 0);

        // out_ready pattern 1,0,0,1
        push(4'd2, 4'd1, 1'b0);
        push(4'd15, 4'd2, 1'b0);
        push(4'd0, 4'd3, 1'b1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        chk("t4_s0", int'(bus.out_score), 15);
        chk("t4_i0", int'(bus.out_id), 2);
        @(posedge clk);
        model_hs(1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            chk("t4_stall_valid", int'(bus.out_valid), 1);
            chk("t4_stall_score", int'(bus.out_score), 2);
            chk("t4_stall_id", int'(bus.out_id), 1);
            chk("t4_stall_last", int'(bus.out_last), 0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        chk("t4_s1", int'(bus.out_score), 2);
        chk("t4_i1", int'(bus.out_id), 1);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        model_hs(1'b0);
        pop(4'd0, 4'd3, 1'b1);

        // Single-entry batch at max score
        push(4'd15, 4'd5, 1'b1);
        chk("t5_busy", int'(busy), 1);
        pop(4'd15, 4'd5, 1'b1);
        chk("t5_busy_after", int'(busy), 0);
        chk("t5_in_ready_after", int'(bus.in_ready), 1);

        // Reset after two outputs of a four-entry batch
        for (int i = 0; i < 4; i++) push(t5[i].s, t5[i].id, t5[i].last);
        for (int i = 0; i < 2; i++) pop(t5[i].es, t5[i].eid, t5[i].elast);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", int'(bus.out_valid), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_in_ready", int'(bus.in_ready), 1);
        chk("t6_rst_out_score", int'(bus.out_score), 0);
`ifdef RANK_IDX_EN
        chk("t6_rst_rank", int'(out_rank), 0);
        exp_rank = 0;
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) push(t6[i].s, t6[i].id, t6[i].last);
        for (int i = 0; i < 3; i++) pop(t6[i].es, t6[i].eid, t6[i].elast);
        @(negedge clk);
        chk("t6_out_valid_after", int'(bus.out_valid), 0);
        chk("t6_busy_after", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/pr_rank_sorter.md
Name: pr_rank_sorter

Overview:
- Sequential back end for the score comparators: collects a batch of (score, node_id) PageRank results and emits them in descending score order.
- Uses the same less/greater/equal decision on each buffered slot, applied in parallel against the incoming score.
- Sits between the PageRank score generator (upstream) and the result/readout logic (downstream).
- Uses valid/ready handshakes on both sides.

Parameters:
- SCORE_W, 4, score width in bits (unsigned).
- ID_W, 4, node identifier width.
- DEPTH, 8, maximum entries per batch (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  block can accept an entry this cycle.
- in_score  input  SCORE_W  entry score.
- in_id  input  ID_W  entry node id.
- in_last  input  1  final entry of batch.
- out_valid  output  1  sorted entry available.
- out_ready  input  1  downstream accepts entry.
- out_score  output  SCORE_W  current highest remaining score.
- out_id  output  ID_W  node id of out_score.
- out_last  output  1  current output is final entry of batch.
- busy  output  1  high in DRAIN or when count>0.

Behaviour:
- Storage is a DEPTH-slot register array (score, id), slot 0 = highest. count is 0..DEPTH.
- States: LOAD, DRAIN.
- Reset (async, rst=1): state=LOAD, count=0, all slots=0, out_valid=0, out_score=0, out_id=0, out_last=0, busy=0, in_ready=1.
- LOAD:
  - in_ready=1, out_valid=0.
  - Accept on in_valid&&in_ready.
  - Insertion position p = number of occupied slots whose score >= in_score. Equal scores go after existing entries, so the sort is stable (arrival order).
  - Slots p..count-1 shift down one; the new entry is written to slot p; count++. All of this happens in the same clock edge.
- LOAD -> DRAIN: on the edge of accepting an entry with in_last=1, or the entry that makes count==DEPTH. The DEPTH-th entry implicitly ends the batch even without in_last.
- Latency: first out_valid is the cycle after the terminating entry is accepted.
- DRAIN:
  - in_ready=0, out_valid=1.
  - out_score/out_id driven from slot 0 (combinational from registers).
  - out_last = (count==1).
  - On out_valid&&out_ready: slots shift up one, slot count-1 cleared to 0, count--.
  - On the handshake with out_last=1, next state is LOAD with count=0, so in_ready=1 the following cycle.
  - out_valid held with stable data while out_ready=0 (no drop, no change).
- busy = (state==DRAIN) || (count!=0).
- in_valid with in_last=1 as the first entry: single-entry batch; DRAIN emits it with out_last=1.
- Boundaries:
  - in_valid in DRAIN is ignored (not accepted).
  - in_last on an entry accepted when count==DEPTH-1: single transition, no double effect.
  - Scores compared unsigned; max (all ones) and 0 both legal.
- Reset asserted mid-LOAD or mid-DRAIN discards the batch immediately. Outputs return to reset values asynchronously.

Optional Feature:
- Macro RANK_IDX_EN.
- When defined: adds output out_rank, width clog2(DEPTH), reset 0. It holds the 0-based position of the current output within the batch and increments on each DRAIN handshake. It returns to 0 on the handshake with out_last=1.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then scores 3,9,1,9 (ids 0,1,2,3), last on id 3, out_ready=1 -> outputs (9,1),(9,3),(3,0),(1,2); out_last only on (1,2); in_ready=0 during drain, 1 the cycle after.
- Eight entries without in_last (DEPTH=8), scores 0..7 -> drain starts after 8th acceptance; emits 7..0; 9th in_valid not accepted until drain completes.
- Drain with out_ready toggling 1,0,0,1 -> out_score/out_id stable while out_ready=0; no entry lost or duplicated.
- Single entry (score 15, id 5, in_last=1) -> one output (15,5) with out_last=1, busy falls the cycle after the handshake.
- Assert rst for one cycle mid-drain after two outputs -> out_valid=0, busy=0, in_ready=1 immediately; next batch sorts correctly with no stale entries.
- With RANK_IDX_EN: 4-entry batch -> out_rank 0,1,2,3, then 0 on the next batch's first output.
